// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00100;
  localparam logic [4:0] OP_OR     = 5'b00101;
  localparam logic [4:0] OP_XOR    = 5'b00110;
  localparam logic [4:0] OP_NOR    = 5'b00111;
  localparam logic [4:0] OP_SHL16  = 5'b01000;
  localparam logic [4:0] OP_SLL    = 5'b01001;
  localparam logic [4:0] OP_SRL    = 5'b01010;
  localparam logic [4:0] OP_SRA    = 5'b01011;
  localparam logic [4:0] OP_INC4   = 5'b01100;
  localparam logic [4:0] OP_DEC4   = 5'b01101;
  localparam logic [4:0] OP_POPCNT = 5'b01110;
  localparam logic [4:0] OP_SLT    = 5'b01111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_DIVU   = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  // Widest datapath the popcount helper covers; callers zero-extend into it.
  localparam int POP_MAXW = 128;

  function automatic logic [7:0] popcount(input logic [POP_MAXW-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < POP_MAXW; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle operation classes of the ALU; unknown opcodes produce zero.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result
);

  logic [SHW-1:0] shamt;
  assign shamt = in2[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:    result = in1 + in2;
      OP_SUB:    result = in1 - in2;
      OP_AND:    result = in1 & in2;
      OP_OR:     result = in1 | in2;
      OP_XOR:    result = in1 ^ in2;
      OP_NOR:    result = ~(in1 | in2);
      OP_SHL16:  result = in1 << 16;
      OP_SLL:    result = in1 << shamt;
      OP_SRL:    result = in1 >> shamt;
      OP_SRA:    result = $signed(in1) >>> shamt;
      OP_INC4:   result = in1 + WIDTH'(4);
      OP_DEC4:   result = in1 - WIDTH'(4);
      OP_POPCNT: result = WIDTH'(popcount(POP_MAXW'(in1)));
      OP_SLT:    result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             div_by_zero
);

  state_t            state_reg, state_next;
  logic [CNTW-1:0]   cnt_reg;
  // a_reg: multiplicand (MUL) or dividend/quotient shifter (DIV)
  // b_reg: multiplier (MUL) or divisor (DIV); acc_reg: product or remainder
  logic [WIDTH-1:0]  a_reg, b_reg, acc_reg;
  logic              rem_sel_reg;
  logic [WIDTH-1:0]  result_reg;
  logic              zero_reg, sign_reg, dbz_reg;

  logic              accept, is_mul_op, is_div_op, last_iter;
  logic [WIDTH-1:0]  comb_result;
  logic [WIDTH-1:0]  mul_acc_next;
  logic [WIDTH:0]    div_shift, div_diff;
  logic              div_fits;
  logic [WIDTH-1:0]  div_rem_next, div_q_next;
  logic              res_load;
  logic [WIDTH-1:0]  res_value;
  logic              dbz_value;

  alu_comb_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .result (comb_result)
  );

  assign in_ready    = (state_reg == S_IDLE);
  assign out_valid   = (state_reg == S_DONE);
  assign accept      = in_valid && in_ready;
  assign is_mul_op   = (op == OP_MUL);
  assign is_div_op   = (op == OP_DIVU) || (op == OP_REMU);
  assign last_iter   = (cnt_reg == CNTW'(WIDTH - 1));
  assign result      = result_reg;
  assign zero        = zero_reg;
  assign sign        = sign_reg;
  assign div_by_zero = dbz_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = is_mul_op ? S_MUL : (is_div_op ? S_DIV : S_DONE);
      S_MUL:  if (last_iter) state_next = S_DONE;
      S_DIV:  if (last_iter) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One multiply step and one restoring-divide step per cycle.
  always_comb begin
    mul_acc_next = acc_reg + (b_reg[0] ? a_reg : '0);
    div_shift    = {acc_reg, a_reg[WIDTH-1]};
    div_diff     = div_shift - {1'b0, b_reg};
    div_fits     = ~div_diff[WIDTH];
    div_rem_next = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q_next   = {a_reg[WIDTH-2:0], div_fits};
  end

  always_comb begin
    res_load  = 1'b0;
    res_value = '0;
    dbz_value = 1'b0;
    case (state_reg)
      S_IDLE: if (accept && !is_mul_op && !is_div_op) begin
        res_load  = 1'b1;
        res_value = comb_result;
      end
      S_MUL: if (last_iter) begin
        res_load  = 1'b1;
        res_value = mul_acc_next;
      end
      S_DIV: if (last_iter) begin
        res_load  = 1'b1;
        res_value = rem_sel_reg ? div_rem_next : div_q_next;
        dbz_value = (b_reg == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      rem_sel_reg <= 1'b0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      sign_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (accept) begin
          a_reg       <= in1;
          b_reg       <= in2;
          acc_reg     <= '0;
          cnt_reg     <= '0;
          rem_sel_reg <= (op == OP_REMU);
        end
        S_MUL: begin
          acc_reg <= mul_acc_next;
          a_reg   <= a_reg << 1;
          b_reg   <= b_reg >> 1;
          cnt_reg <= cnt_reg + CNTW'(1);
        end
        S_DIV: begin
          acc_reg <= div_rem_next;
          a_reg   <= div_q_next;
          cnt_reg <= cnt_reg + CNTW'(1);
        end
        default: ;
      endcase
      if (res_load) begin
        result_reg <= res_value;
        zero_reg   <= (res_value == '0);
        sign_reg   <= res_value[WIDTH-1];
        dbz_reg    <= dbz_value;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench: randomized and directed ops against an arithmetic model,
// plus a 16-bit instance for width-parametrisation checks.
module tb_multicycle_alu;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] in1, in2, result;
  logic        zero, sign, div_by_zero;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [4:0]  op16;
  logic [15:0] in1_16, in2_16, result16;
  logic        zero16, sign16, dbz16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rdy_rand = 1'b0;
  logic rdy_val = 1'b1;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .sign(sign), .div_by_zero(div_by_zero)
  );

  multicycle_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .in1(in1_16), .in2(in2_16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .zero(zero16), .sign(sign16), .div_by_zero(dbz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (o)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = ~(a | b);
      5'd8:  r = a << 16;
      5'd9:  r = a << b[4:0];
      5'd10: r = a >> b[4:0];
      5'd11: r = $signed(a) >>> b[4:0];
      5'd12: r = a + 32'd4;
      5'd13: r = a - 32'd4;
      5'd14: r = $countones(a);
      5'd15: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd16: r = a * b;
      5'd17: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd18: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Monitor: drive out_ready for the coming edge, then check what is presented.
  always @(negedge clk) begin
    exp_t e;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb[0];
        if (!prev_valid) chk("latency_cycle", 64'(cyc), 64'(e.exp_cyc));
        chk("result", 64'(result), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.res == 0));
        chk("sign", 64'(sign), 64'(e.res[31]));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        if (out_ready) begin
          $display("txn cycle=%0d result=%h dbz=%b", cyc, result, div_by_zero);
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = out_valid && !rst;
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    e.res = ref_model(o, a, b);
    e.dbz = ((o == 5'd17) || (o == 5'd18)) && (b == 0);
    e.exp_cyc = cyc + 1 + (((o == 5'd16) || (o == 5'd17) || (o == 5'd18)) ? 32 : 0);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; op = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic run16(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expv, input int lat);
    int acc_cyc;
    int n = 0;
    @(negedge clk);
    in_valid16 = 1'b1; op16 = o; in1_16 = a; in2_16 = b;
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid16 = 1'b0; in1_16 = 16'($urandom); in2_16 = 16'($urandom);
    while (!out_valid16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w16_latency", 64'(cyc), 64'(acc_cyc + lat));
    chk("w16_result", 64'(result16), 64'(expv));
    chk("w16_sign", 64'(sign16), 64'(expv[15]));
    $display("txn16 cycle=%0d result=%h", cyc, result16);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] op_tab [20];
    int n;
    op_tab = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
               5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd2, 5'd19, 5'd31};
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
    in_valid16 = 1'b0; op16 = '0; in1_16 = '0; in2_16 = '0; out_ready16 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_zero", 64'(zero), 64'd0);
    chk("reset_sign", 64'(sign), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    issue(5'd0, 32'h7FFF_FFFF, 32'd1);
    drain();

    // Stalled consumer: result must stay presented and no new op accepted.
    rdy_val = 1'b0;
    issue(5'd1, 32'd5, 32'd5);
    repeat (4) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    rdy_val = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("release_in_ready", 64'(in_ready), 64'd1);
    drain();

    issue(5'd16, 32'hFFFF_FFFF, 32'd3);
    in_valid = 1'b1; op = 5'd0; in1 = 32'd1; in2 = 32'd1;
    repeat (3) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    issue(5'd17, 32'd100, 32'd7);
    issue(5'd18, 32'd100, 32'd7);
    issue(5'd17, 32'd9, 32'd0);
    issue(5'd18, 32'd9, 32'd0);
    issue(5'd11, 32'h8000_0000, 32'h24);
    issue(5'd14, 32'hF0F0_000F, 32'd0);
    issue(5'd8, 32'h1234, 32'd0);
    issue(5'd13, 32'd2, 32'd0);
    drain();

    // Randomized traffic with a random consumer.
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      issue(op_tab[$urandom_range(0, 19)], a, b);
    end
    drain();

    // Reset in the middle of a divide aborts it.
    issue(5'd17, $urandom, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd0);
    chk("midrst_sign", 64'(sign), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    issue(5'd0, 32'd1, 32'd1);
    drain();

    run16(5'd0, 16'h7FFF, 16'h0001, 16'h8000, 0);
    run16(5'd16, 16'hFFFF, 16'h0003, 16'hFFFD, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
